mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
Iterative multiply/divide unit in the EX stage. It consumes the operand_1/operand_2 pair produced by the ID-stage operand generator and executes MULT/MULTU/DIV/DIVU over multiple cycles into architectural HI/LO registers. It also services MTHI/MTLO, supplies HI/LO for MFHI/MFLO, and raises a stall request so the pipeline holds while an operation is in flight.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; must equal the codebase data-bus width.
ITERATIONS, 32, radix-2 steps per multiply/divide; fixed equal to DATA_WIDTH.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  EX instruction valid for this unit this cycle
funct  input  6  SPECIAL funct: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13; any other value is ignored
operand_1  input  32  rs value; multiplicand / dividend / MTHI/MTLO source
operand_2  input  32  rt value; multiplier / divisor
flush  input  1  pipeline flush (exception/branch kill); aborts the current operation
stall_req  output  1  combinational; request pipeline stall
busy  output  1  registered; operation in progress
done  output  1  registered one-cycle pulse when HI/LO take a new mul/div result
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; hi=0; lo=0; busy=0; done=0; counter=0; all operand/temp registers cleared.
- States: IDLE, MUL, DIV, FIN.
- IDLE, start=1, flush=0:
  - MULT/MULTU latch operands and go to MUL.
  - DIV/DIVU with operand_2!=0 latch operands and go to DIV.
  - DIV/DIVU with operand_2==0 go directly to FIN with result hi=operand_1, lo=0xFFFFFFFF. This is a defined value; there is no trap.
  - MTHI writes hi<=operand_1; MTLO writes lo<=operand_1. Both take effect next edge, stay in IDLE, no stall, done stays 0.
- Signed ops latch absolute values, plus negate_q = sign1^sign2 and negate_r = sign1. Unsigned ops clear both flags.
- MUL: 32 shift-add steps on a 64-bit accumulator, one step per cycle, counter 0..31. After step 31 go to FIN.
- DIV: 32 restoring shift-subtract steps producing a 32-bit quotient and remainder. After step 31 go to FIN.
- FIN (one cycle), at its closing edge:
  - Mul: {hi,lo} <= product, two's-complemented if negate_q.
  - Div: lo <= quotient (negated if negate_q); hi <= remainder (negated if negate_r).
  - done=1 for exactly this one registered cycle. Return to IDLE.
- Latency, with start accepted at edge T:
  - busy=1 in cycles T+1..T+33 (32 iterations plus FIN).
  - New hi/lo and done=1 visible in cycle T+34; busy=0 in that cycle.
  - Divide-by-zero: busy in cycle T+1, result visible at T+2.
- stall_req = busy | (start & state==IDLE & funct is MULT/MULTU/DIV/DIVU & ~flush). It is high in the issue cycle and stays high through FIN. It is low in the cycle the result is visible, so a dependent MFHI/MFLO issued then reads the new hi/lo.
- start while not IDLE is ignored. The stalled pipeline keeps presenting the same instruction; the unit does not re-launch it.
- flush=1 in any state: next state IDLE, busy=0, done=0, hi/lo unchanged (a pending result is discarded, including in FIN). flush wins over simultaneous start.
- Reset mid-operation: immediate return to reset values. No partial write to hi/lo.
- Arithmetic is modulo 2^32 per half. Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.

Test Plan:
- MULT op1=0xFFFFFFFD(-3), op2=7 -> done at T+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; stall_req high T..T+33.
- MULTU op1=0xFFFFFFFF, op2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 -> lo=14, hi=2. DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 5/0 -> done at T+2; hi=5, lo=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678, then next cycle MTLO 0xCAFEBABE -> hi/lo updated one edge each, stall_req=0, done=0. Then MULT with flush at T+10 -> busy=0 at T+11, hi/lo still 0x12345678/0xCAFEBABE.
- Assert rst at T+20 of a DIVU -> hi=lo=0, busy=0 immediately. A new MULTU 3*4 then completes with lo=12, hi=0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO pair.
// MULT/MULTU/DIV/DIVU take 32 iterations plus a finish cycle; MTHI/MTLO write in one edge.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ITERATIONS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(ITERATIONS);
  localparam logic [CW-1:0] LAST_STEP = CW'(ITERATIONS - 1);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
    return ~x + {{(W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x);
    return ~x + {{(2*W-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_r, next_state_s;
  logic [CW-1:0]    cnt_r;
  logic [2*W-1:0]   acc_r;
  logic [W-1:0]     op_r;
  logic             neg_q_r, neg_r_r, is_div_r;
  logic [W-1:0]     hi_r, lo_r;
  logic             busy_r, done_r;

  logic             idle_go_s, is_mul_s, is_div_s, is_signed_s;
  logic [W-1:0]     abs1_s, abs2_s;
  logic [W:0]       mul_sum_s;
  logic [2*W-1:0]   mul_step_s, div_step_s;
  logic [W:0]       div_shift_s;
  logic [W-1:0]     div_diff_s;
  logic             div_geq_s;

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // Instruction decode and operand sign handling for a launch from IDLE.
  always_comb begin
    idle_go_s   = start & (state_r == IDLE) & ~flush;
    is_mul_s    = (funct == F_MULT) | (funct == F_MULTU);
    is_div_s    = (funct == F_DIV)  | (funct == F_DIVU);
    is_signed_s = (funct == F_MULT) | (funct == F_DIV);
    if (is_signed_s && operand_1[W-1]) begin
      abs1_s = neg_w(operand_1);
    end else begin
      abs1_s = operand_1;
    end
    if (is_signed_s && operand_2[W-1]) begin
      abs2_s = neg_w(operand_2);
    end else begin
      abs2_s = operand_2;
    end
  end

  // One shift-add multiply step and one restoring divide step on the shared accumulator.
  always_comb begin
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*W-1:W]} + {1'b0, op_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*W-1:W]};
    end
    mul_step_s  = {mul_sum_s, acc_r[W-1:1]};
    div_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
    div_geq_s   = div_shift_s >= {1'b0, op_r};
    div_diff_s  = div_shift_s[W-1:0] - op_r;
    if (div_geq_s) begin
      div_step_s = {div_diff_s, acc_r[W-2:0], 1'b1};
    end else begin
      div_step_s = {div_shift_s[W-1:0], acc_r[W-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    next_state_s = state_r;
    if (flush) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (idle_go_s && is_mul_s) begin
            next_state_s = MUL;
          end else if (idle_go_s && is_div_s) begin
            next_state_s = (operand_2 == {W{1'b0}}) ? FIN : DIV;
          end else begin
            next_state_s = IDLE;
          end
        end
        MUL:     next_state_s = (cnt_r == LAST_STEP) ? FIN : MUL;
        DIV:     next_state_s = (cnt_r == LAST_STEP) ? FIN : DIV;
        FIN:     next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Stall covers the issue cycle and every busy cycle, releasing when the result lands.
  always_comb begin
    if (busy_r) begin
      stall_req = 1'b1;
    end else begin
      stall_req = idle_go_s & (is_mul_s | is_div_s);
    end
  end

  // Datapath, HI/LO and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*W){1'b0}};
      op_r     <= {W{1'b0}};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      is_div_r <= 1'b0;
      hi_r     <= {W{1'b0}};
      lo_r     <= {W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (next_state_s != IDLE);
      done_r <= (state_r == FIN) & ~flush;
      case (state_r)
        IDLE: begin
          cnt_r <= {CW{1'b0}};
          if (idle_go_s && is_mul_s) begin
            acc_r    <= {{W{1'b0}}, abs2_s};
            op_r     <= abs1_s;
            neg_q_r  <= is_signed_s & (operand_1[W-1] ^ operand_2[W-1]);
            neg_r_r  <= is_signed_s & operand_1[W-1];
            is_div_r <= 1'b0;
          end else if (idle_go_s && is_div_s && (operand_2 == {W{1'b0}})) begin
            // Divide by zero: defined result staged directly for FIN.
            acc_r    <= {operand_1, {W{1'b1}}};
            op_r     <= {W{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            is_div_r <= 1'b1;
          end else if (idle_go_s && is_div_s) begin
            acc_r    <= {{W{1'b0}}, abs1_s};
            op_r     <= abs2_s;
            neg_q_r  <= is_signed_s & (operand_1[W-1] ^ operand_2[W-1]);
            neg_r_r  <= is_signed_s & operand_1[W-1];
            is_div_r <= 1'b1;
          end else if (idle_go_s && (funct == F_MTHI)) begin
            hi_r <= operand_1;
          end else if (idle_go_s && (funct == F_MTLO)) begin
            lo_r <= operand_1;
          end else begin
            acc_r <= acc_r;
          end
        end
        MUL: begin
          acc_r <= mul_step_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        DIV: begin
          acc_r <= div_step_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        FIN: begin
          if (flush) begin
            hi_r <= hi_r;
          end else if (is_div_r) begin
            lo_r <= neg_q_r ? neg_w(acc_r[W-1:0]) : acc_r[W-1:0];
            hi_r <= neg_r_r ? neg_w(acc_r[2*W-1:W]) : acc_r[2*W-1:W];
          end else begin
            {hi_r, lo_r} <= neg_q_r ? neg_2w(acc_r) : acc_r;
          end
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule
